// File: rtl/err_inject_ctrl_pkg.sv
// Shared definitions for the BERT error-injection controller: default
// widths, run-mode and FSM state encodings, and a small clamp helper.
package err_pkg;

    localparam int DEF_WIDTH = 13;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_SINGLE   = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_BURST    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_ARMED = 2'b10
    } state_e;

    // A burst length of zero is treated as a single word
    function automatic logic [3:0] burst_clamp(input logic [3:0] len);
        return (len == 4'd0) ? 4'd1 : len;
    endfunction

endpackage

// File: rtl/err_inject_ctrl_if.sv
// Configuration / status bundle between the BERT sequencer and the
// error-injection controller.
interface err_inject_ctrl_if #(
    parameter int WIDTH = err_pkg::DEF_WIDTH,
    parameter int CNT_W = err_pkg::DEF_CNT_W
) ();
    logic             start;
    logic             stop;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [3:0]       cfg_burst_len;
    logic [3:0]       cfg_seed;
    logic             word_valid;
    logic             clr_count;
    logic [WIDTH-1:0] err_mask;
    logic [CNT_W-1:0] err_count;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, cfg_mode, cfg_period, cfg_burst_len, cfg_seed,
               word_valid, clr_count,
        input  err_mask, err_count, busy, done
    );

    modport slave (
        input  start, stop, cfg_mode, cfg_period, cfg_burst_len, cfg_seed,
               word_valid, clr_count,
        output err_mask, err_count, busy, done
    );
endinterface

// File: rtl/err_inject_ctrl_pos_gen.sv
// Modulo-WIDTH bit-position counter with seed load. Exposes the one-hot
// decode of the position that will hold after this clock edge, so the
// caller can register the flip mask without an extra cycle of lag.
module err_pos_gen #(
    parameter int WIDTH = err_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [3:0]       i_seed,
    input  logic             i_advance,
    output logic [WIDTH-1:0] o_onehot_next
);
    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1'b1);

    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_next;

    // Next position: seed load wins, otherwise wrap-around increment per consumed word
    always_comb begin
        w_pos_next = r_pos;
        if (i_load) begin
            if (int'(i_seed) >= WIDTH) begin
                w_pos_next = {POS_W{1'b0}};
            end else begin
                w_pos_next = POS_W'(i_seed);
            end
        end else if (i_advance) begin
            if (r_pos == POS_LAST) begin
                w_pos_next = {POS_W{1'b0}};
            end else begin
                w_pos_next = r_pos + POS_ONE;
            end
        end else begin
            w_pos_next = r_pos;
        end
    end

    // Position register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= {POS_W{1'b0}};
        end else begin
            r_pos <= w_pos_next;
        end
    end

    assign o_onehot_next = {{(WIDTH-1){1'b0}}, 1'b1} << w_pos_next;

endmodule

// File: rtl/err_inject_ctrl.sv
// Error-injection sequencer for the BERT transmit path. Chooses which
// pattern word gets corrupted (single, periodic or burst) and which bit is
// flipped, and counts every injected word with saturation.
module err_inject_ctrl
    import err_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    err_inject_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [3:0]       BURST_ONE = 4'd1;

    state_e           r_state, w_state_next;
    mode_e            r_mode;
    logic [CNT_W-1:0] r_period, r_cnt, w_period_eff;
    logic [CNT_W-1:0] r_err_count, w_count_next;
    logic [3:0]       r_burst_left;
    logic [WIDTH-1:0] r_err_mask, w_mask_next, w_onehot_next;
    logic             r_done, w_done_next, r_busy;
    logic             w_start_ok, w_consume, w_last_of_run;

    assign w_period_eff  = (bus.cfg_period == CNT_ZERO) ? CNT_ONE : bus.cfg_period;
    assign w_start_ok    = bus.start && !bus.stop && (r_state == S_IDLE);
    assign w_consume     = (r_state == S_ARMED) && bus.word_valid;
    assign w_last_of_run = (r_mode == MODE_SINGLE) ||
                           ((r_mode == MODE_BURST) && (r_burst_left <= BURST_ONE));

    err_pos_gen #(.WIDTH(WIDTH)) u_pos_gen (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_start_ok),
        .i_seed        (bus.cfg_seed),
        .i_advance     (w_consume),
        .o_onehot_next (w_onehot_next)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; stop overrides everything
    always_comb begin
        w_state_next = r_state;
        if (bus.stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (mode_e'(bus.cfg_mode) != MODE_OFF)) begin
                        w_state_next = (w_period_eff == CNT_ONE) ? S_ARMED : S_COUNT;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_COUNT: begin
                    if (bus.word_valid && (r_cnt == CNT_ONE)) begin
                        w_state_next = S_ARMED;
                    end else begin
                        w_state_next = S_COUNT;
                    end
                end
                S_ARMED: begin
                    if (bus.word_valid) begin
                        case (r_mode)
                            MODE_PERIODIC: w_state_next = (r_period == CNT_ONE) ? S_ARMED : S_COUNT;
                            MODE_BURST:    w_state_next = (r_burst_left > BURST_ONE) ? S_ARMED : S_IDLE;
                            default:       w_state_next = S_IDLE;
                        endcase
                    end else begin
                        w_state_next = S_ARMED;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs: mask, done pulse, saturating count
    always_comb begin
        w_mask_next  = {WIDTH{1'b0}};
        w_done_next  = 1'b0;
        w_count_next = r_err_count;
        if (w_state_next == S_ARMED) begin
            w_mask_next = w_onehot_next;
        end else begin
            w_mask_next = {WIDTH{1'b0}};
        end
        if (w_consume && !bus.stop && w_last_of_run) begin
            w_done_next = 1'b1;
        end else begin
            w_done_next = 1'b0;
        end
        if (bus.clr_count) begin
            w_count_next = w_consume ? CNT_ONE : CNT_ZERO;
        end else if (w_consume && (r_err_count != CNT_MAX)) begin
            w_count_next = r_err_count + CNT_ONE;
        end else begin
            w_count_next = r_err_count;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_mask  <= {WIDTH{1'b0}};
            r_err_count <= CNT_ZERO;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_err_mask  <= w_mask_next;
            r_err_count <= w_count_next;
            r_done      <= w_done_next;
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    // Shadow configuration and interval/burst counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= MODE_OFF;
            r_period     <= CNT_ONE;
            r_cnt        <= CNT_ZERO;
            r_burst_left <= BURST_ONE;
        end else if (w_start_ok) begin
            r_mode       <= mode_e'(bus.cfg_mode);
            r_period     <= w_period_eff;
            r_cnt        <= w_period_eff - CNT_ONE;
            r_burst_left <= burst_clamp(bus.cfg_burst_len);
        end else if ((r_state == S_COUNT) && bus.word_valid && !bus.stop) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else if (w_consume && !bus.stop) begin
            if (r_mode == MODE_PERIODIC) begin
                r_cnt <= r_period - CNT_ONE;
            end else if ((r_mode == MODE_BURST) && (r_burst_left > BURST_ONE)) begin
                r_burst_left <= r_burst_left - BURST_ONE;
            end
        end
    end

    assign bus.err_mask  = r_err_mask;
    assign bus.err_count = r_err_count;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
